trace_sched_ctrl: RTL and testbench

- Sequencer for the trace datapath in the ML detector.
- Sweeps NUM_CAND candidate G matrices held in a banked G_RAM. For each one it:
  - selects the bank,
  - pulses the trace engine's start,
  - waits for its done,
  - compares Re{trace(Y^H·G)} against the running best.
- Reports the index and trace of the maximising candidate to the downstream decision logic.

---
 rtl/trace_sched_ctrl_pkg.sv | 30 +++
 rtl/trace_sched_ctrl_if.sv | 42 ++++
 rtl/trace_sched_ctrl_max_tracker.sv | 57 +++++
 rtl/trace_sched_ctrl.sv | 165 ++++++++++++++++
 tb/tb_trace_sched_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_sched_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trace_sched_ctrl_pkg
// Shared definitions for the ML-detector trace sequencer and its helpers:
//   - default widths / counts for the trace datapath
//   - controller state encoding
//   - candidate-result record {idx, r, i} at the default widths
// No ports (package).
// -----------------------------------------------------------------------------
package trace_sched_ctrl_pkg;

    localparam int DEF_N        = 16;
    localparam int DEF_NUM_CAND = 16;
    localparam int DEF_CAND_W   = 4;
    localparam int DEF_TIMEOUT  = 63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic        [DEF_CAND_W-1:0] idx;
        logic signed [DEF_N-1:0]      r;
        logic signed [DEF_N-1:0]      i;
    } cand_res_t;

endpackage

// File: rtl/trace_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// trace_sched_ctrl_if
// Bundles the job handshake, the trace-engine handshake and the result bus of
// the trace sequencer.
//   master : the sequencer (drives job_ready, trc_start, g_bank_sel, job_done,
//            best_idx/best_r/best_i, err_timeout)
//   slave  : the environment (drives job_start, abort, trc_done, trc_r, trc_i)
// -----------------------------------------------------------------------------
interface trace_sched_ctrl_if
    import trace_sched_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int CAND_W = DEF_CAND_W
) ();

    logic                     job_start;
    logic                     abort;
    logic                     job_ready;
    logic                     trc_start;
    logic                     trc_done;
    logic signed [N-1:0]      trc_r;
    logic signed [N-1:0]      trc_i;
    logic        [CAND_W-1:0] g_bank_sel;
    logic                     job_done;
    logic        [CAND_W-1:0] best_idx;
    logic signed [N-1:0]      best_r;
    logic signed [N-1:0]      best_i;
    logic                     err_timeout;

    modport master (
        input  job_start, abort, trc_done, trc_r, trc_i,
        output job_ready, trc_start, g_bank_sel, job_done,
               best_idx, best_r, best_i, err_timeout
    );

    modport slave (
        output job_start, abort, trc_done, trc_r, trc_i,
        input  job_ready, trc_start, g_bank_sel, job_done,
               best_idx, best_r, best_i, err_timeout
    );

endinterface

// File: rtl/trace_sched_ctrl_max_tracker.sv
// -----------------------------------------------------------------------------
// trace_max_tracker
// Running arg-max register: keeps the candidate with the largest signed real
// part seen since the last clear. The first candidate after a clear is always
// taken; afterwards only a strictly greater real part replaces the best, so
// ties keep the earlier (lower) index. The imaginary part rides along.
// Ports:
//   clk, rst       clock, synchronous active-high reset (best <= 0)
//   i_clr          restart tracking (best <= 0, next update always taken)
//   i_upd          offer candidate {i_idx, i_r, i_i}
//   o_idx/o_r/o_i  current best candidate
// -----------------------------------------------------------------------------
module trace_max_tracker
    import trace_sched_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int CAND_W = DEF_CAND_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_upd,
    input  logic        [CAND_W-1:0] i_idx,
    input  logic signed [N-1:0]      i_r,
    input  logic signed [N-1:0]      i_i,
    output logic        [CAND_W-1:0] o_idx,
    output logic signed [N-1:0]      o_r,
    output logic signed [N-1:0]      o_i
);

    logic                     r_first;
    logic        [CAND_W-1:0] r_idx;
    logic signed [N-1:0]      r_best_r;
    logic signed [N-1:0]      r_best_i;
    logic                     w_take;

    assign w_take = r_first || (i_r > r_best_r);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_first  <= 1'b1;
            r_idx    <= '0;
            r_best_r <= '0;
            r_best_i <= '0;
        end else if (i_upd && w_take) begin
            r_first  <= 1'b0;
            r_idx    <= i_idx;
            r_best_r <= i_r;
            r_best_i <= i_i;
        end
    end

    assign o_idx = r_idx;
    assign o_r   = r_best_r;
    assign o_i   = r_best_i;

endmodule

// File: rtl/trace_sched_ctrl.sv
// -----------------------------------------------------------------------------
// trace_sched_ctrl
// Sequencer for the ML-detector trace datapath. For each of NUM_CAND banked
// G candidates it selects the bank, pulses the trace engine, waits for done
// and keeps the candidate with the largest Re{trace(Y^H G)}.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   trace_sched_ctrl_if.master (job handshake, engine handshake, result)
// Optional build macro TRACE_SCHED_WDOG_EN: adds a WAIT watchdog of TIMEOUT
// cycles that sets the sticky err_timeout flag and ends the sweep early.
// Without it err_timeout is tied low and WAIT waits indefinitely.
// -----------------------------------------------------------------------------
module trace_sched_ctrl
    import trace_sched_ctrl_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CAND_W   = DEF_CAND_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    trace_sched_ctrl_if.master bus
);

    if (NUM_CAND < 2 || (2 ** CAND_W) < NUM_CAND || TIMEOUT < 1) begin : g_cfg_check
        $error("trace_sched_ctrl: invalid NUM_CAND/CAND_W/TIMEOUT combination");
    end

    state_t                   r_state;
    logic        [CAND_W-1:0] r_cand;
    logic                     r_trc_start;
    logic                     r_job_done;
    logic signed [N-1:0]      r_cur_r;
    logic signed [N-1:0]      r_cur_i;

    logic w_accept;
    logic w_upd;
    logic w_last;

    // abort in IDLE also blocks acceptance of a simultaneous job_start
    assign w_accept = (r_state == ST_IDLE) && bus.job_start && !bus.abort;
    assign w_upd    = (r_state == ST_UPDATE) && !bus.abort;
    assign w_last   = (r_cand == CAND_W'(NUM_CAND - 1));

`ifdef TRACE_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] r_wcnt;
    logic              r_err;
    logic              w_wdog_fire;

    // r_wcnt counts WAIT cycles already spent, so it fires in the TIMEOUT-th one
    assign w_wdog_fire = (r_state == ST_WAIT) && !bus.trc_done &&
                         (r_wcnt == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)
                r_wcnt <= '0;
            else if (r_state == ST_WAIT)
                r_wcnt <= r_wcnt + 1'b1;

            if (w_accept)
                r_err <= 1'b0;
            else if (w_wdog_fire && !bus.abort)
                r_err <= 1'b1;
        end
    end

    assign bus.err_timeout = r_err;
`else
    assign bus.err_timeout = 1'b0;
`endif

    // trc_start / job_done are registered on the transition into ISSUE / DONE
    // so they are high for exactly the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cand      <= '0;
            r_trc_start <= 1'b0;
            r_job_done  <= 1'b0;
        end else begin
            r_trc_start <= 1'b0;
            r_job_done  <= 1'b0;
            if (bus.abort) begin
                r_state <= ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.job_start) begin
                            r_cand      <= '0;
                            r_state     <= ST_ISSUE;
                            r_trc_start <= 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (bus.trc_done) begin
                            r_state <= ST_UPDATE;
`ifdef TRACE_SCHED_WDOG_EN
                        end else if (w_wdog_fire) begin
                            r_state    <= ST_DONE;
                            r_job_done <= 1'b1;
`endif
                        end
                    end
                    ST_UPDATE: begin
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_job_done <= 1'b1;
                        end else begin
                            r_cand      <= r_cand + 1'b1;
                            r_state     <= ST_ISSUE;
                            r_trc_start <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Trace result is only meaningful in the engine's done cycle while waiting.
    always_ff @(posedge clk) begin
        if ((r_state == ST_WAIT) && bus.trc_done) begin
            r_cur_r <= bus.trc_r;
            r_cur_i <= bus.trc_i;
        end
    end

    trace_max_tracker #(
        .N      (N),
        .CAND_W (CAND_W)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_upd (w_upd),
        .i_idx (r_cand),
        .i_r   (r_cur_r),
        .i_i   (r_cur_i),
        .o_idx (bus.best_idx),
        .o_r   (bus.best_r),
        .o_i   (bus.best_i)
    );

    assign bus.job_ready  = (r_state == ST_IDLE);
    assign bus.trc_start  = r_trc_start;
    assign bus.job_done   = r_job_done;
    assign bus.g_bank_sel = r_cand;

endmodule

// File: tb/tb_trace_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_sched_ctrl
// Self-checking bench for trace_sched_ctrl (NUM_CAND=4). Acts as job master
// and trace engine; expected winners come from a plain arg-max over the
// per-job trace table. Build with TRACE_SCHED_WDOG_EN to add the watchdog job.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trace_sched_ctrl;
    import trace_sched_ctrl_pkg::*;

    localparam int N  = 16;
    localparam int NC = 4;
    localparam int CW = 4;
    localparam int TO = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_sched_ctrl_if #(.N(N), .CAND_W(CW)) bus ();

    trace_sched_ctrl #(
        .N        (N),
        .NUM_CAND (NC),
        .CAND_W   (CW),
        .TIMEOUT  (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int n_start = 0;
    int n_done  = 0;

    logic signed [N-1:0] vr [NC];
    logic signed [N-1:0] vi [NC];
    int                  tw [NC];   // WAIT cycles per candidate; 0 = engine never answers

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.trc_start === 1'b1) n_start++;
        if (bus.job_done === 1'b1) n_done++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Winner = first candidate holding the maximum real part among the first n.
    function automatic cand_res_t ref_best(input int n);
        cand_res_t b;
        b = '0;
        for (int k = 0; k < n; k++) begin
            if (k == 0 || vr[k] > b.r) begin
                b.idx = CW'(k);
                b.r   = vr[k];
                b.i   = vi[k];
            end
        end
        return b;
    endfunction

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready"}, bus.job_ready, 1);
        chk({pfx, "_trc_start"}, bus.trc_start, 0);
        chk({pfx, "_job_done"}, bus.job_done, 0);
        chk({pfx, "_err"}, bus.err_timeout, 0);
        chk({pfx, "_bank"}, bus.g_bank_sel, 0);
        chk({pfx, "_best_idx"}, bus.best_idx, 0);
        chk({pfx, "_best_r"}, bus.best_r, 0);
        chk({pfx, "_best_i"}, bus.best_i, 0);
    endtask

    task automatic rand_job();
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 4))
                0:       vr[k] = 16'sh8000;
                1:       vr[k] = 16'sh7fff;
                2:       vr[k] = N'(int'($urandom_range(0, 2)) - 1);
                default: vr[k] = N'($urandom);
            endcase
            vi[k] = N'($urandom);
            tw[k] = int'($urandom_range(1, 3));
        end
    endtask

    task automatic run_job(input bit hold, input bit stray, input int abort_at, input int rst_at);
        cand_res_t exp;
        int  t0, s0, d0, n_cmp, lat;
        bit  got, cut, wd;
        cut   = 1'b0;
        wd    = 1'b0;
        n_cmp = NC;
        lat   = 1;
        @(negedge clk);
        chk("ready_before", bus.job_ready, 1);
        bus.job_start = 1'b1;
        t0 = cyc;
        s0 = n_start;
        d0 = n_done;
        @(negedge clk);
        if (!hold) bus.job_start = 1'b0;
        for (int k = 0; k < NC && !cut && !wd; k++) begin
            got = 1'b0;
            for (int b = 0; b < 6 && !got; b++) begin
                if (bus.trc_start === 1'b1) got = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("start_seen%0d", k), got, 1);
            chk($sformatf("bank_issue%0d", k), bus.g_bank_sel, k);
            if (stray && k == 1) begin
                bus.trc_done = 1'b1;
                bus.trc_r    = 16'sh7fff;
                bus.trc_i    = 16'sh7fff;
            end
            @(negedge clk);
            bus.trc_done = 1'b0;
            if (tw[k] == 0) begin
                wd    = 1'b1;
                n_cmp = k;
            end else begin
                lat += 2 + tw[k];
                for (int w = 1; w <= tw[k] && !cut; w++) begin
                    chk($sformatf("bank_wait%0d", k), bus.g_bank_sel, k);
                    chk($sformatf("start_once%0d", k), bus.trc_start, 0);
                    if (abort_at == k) begin
                        bus.abort = 1'b1;
                        @(negedge clk);
                        bus.abort = 1'b0;
                        chk("abort_idle", bus.job_ready, 1);
                        chk("abort_no_done", bus.job_done, 0);
                        chk("abort_no_start", bus.trc_start, 0);
                        cut = 1'b1;
                    end else begin
                        if (w == tw[k]) begin
                            bus.trc_done = 1'b1;
                            bus.trc_r    = vr[k];
                            bus.trc_i    = vi[k];
                        end
                        @(negedge clk);
                        bus.trc_done = 1'b0;
                    end
                end
                if (!cut && rst_at == k) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk_zero("midrst");
                    rst = 1'b0;
                    cut = 1'b1;
                end
            end
        end
        if (cut) begin
            bus.job_start = 1'b0;
            repeat (3) @(negedge clk);
            chk("cut_no_done", n_done - d0, 0);
            chk("cut_idle", bus.job_ready, 1);
            return;
        end
        got = 1'b0;
        for (int b = 0; b < (wd ? 100 : 6) && !got; b++) begin
            if (bus.job_done === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", got, 1);
        bus.job_start = 1'b0;
        if (!wd) chk("latency", cyc - t0, lat);
        chk("start_count", n_start - s0, wd ? n_cmp + 1 : NC);
        exp = ref_best(n_cmp);
        chk("best_idx", bus.best_idx, exp.idx);
        chk("best_r", bus.best_r, exp.r);
        chk("best_i", bus.best_i, exp.i);
        chk("err_timeout", bus.err_timeout, wd ? 1 : 0);
        @(negedge clk);
        chk("done_pulse", bus.job_done, 0);
        chk("ready_after", bus.job_ready, 1);
        chk("best_hold", bus.best_idx, exp.idx);
        chk("err_hold", bus.err_timeout, wd ? 1 : 0);
        repeat (2) @(negedge clk);
        chk("no_requeue", n_start - s0, wd ? n_cmp + 1 : NC);
        chk("done_count", n_done - d0, 1);
    endtask

    initial begin
        int s0;
        bus.job_start = 1'b0;
        bus.abort     = 1'b0;
        bus.trc_done  = 1'b0;
        bus.trc_r     = '0;
        bus.trc_i     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // basic sweep
        vr = '{16'sd5, -16'sd3, 16'sd12, 16'sd7};
        vi = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        tw = '{1, 1, 1, 1};
        run_job(1'b0, 1'b0, -1, -1);

        // ties and negatives
        vr = '{-16'sd8, -16'sd2, -16'sd2, -16'sd9};
        vi = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
        run_job(1'b0, 1'b0, -1, -1);

        // job_start held high, stray engine done during ISSUE
        rand_job();
        run_job(1'b1, 1'b1, -1, -1);

        // abort in WAIT of candidate 2, then a fresh job
        rand_job();
        run_job(1'b0, 1'b0, 2, -1);
        rand_job();
        run_job(1'b0, 1'b0, -1, -1);

        // reset while in UPDATE of candidate 1, then a fresh job
        rand_job();
        run_job(1'b0, 1'b0, -1, 1);
        rand_job();
        run_job(1'b0, 1'b0, -1, -1);

        // abort and job_start together in IDLE: not accepted
        @(negedge clk);
        s0 = n_start;
        bus.job_start = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.job_start = 1'b0;
        bus.abort     = 1'b0;
        chk("abort_wins_ready", bus.job_ready, 1);
        chk("abort_wins_start", bus.trc_start, 0);
        @(negedge clk);
        chk("abort_wins_count", n_start - s0, 0);

        repeat (8) begin
            rand_job();
            run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
        end

`ifdef TRACE_SCHED_WDOG_EN
        rand_job();
        tw[1] = 0;
        run_job(1'b0, 1'b0, -1, -1);
        rand_job();
        run_job(1'b0, 1'b0, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
